// File: rtl/free_list_controller_if.sv
// free_list_controller_if: checker push strobes, downstream valid/ready drains, status and flush.
interface free_list_controller_if #(
  parameter int ITER_WIDTH   = 9,
  parameter int FL_PTR_WIDTH = 4,
  parameter int NR_PTR_WIDTH = 4,
  parameter int DROP_WIDTH   = 8
);
  logic                    clear;
  logic                    fl_valid;
  logic [ITER_WIDTH-1:0]   fl_in;
  logic                    nr_valid;
  logic [ITER_WIDTH-1:0]   nr_in;
  logic                    fl_out_valid;
  logic [ITER_WIDTH-1:0]   fl_out_data;
  logic                    fl_out_ready;
  logic                    nr_out_valid;
  logic [ITER_WIDTH-1:0]   nr_out_data;
  logic                    nr_out_ready;
  logic [FL_PTR_WIDTH:0]   fl_count;
  logic [NR_PTR_WIDTH:0]   nr_count;
  logic                    fl_overflow;
  logic                    nr_overflow;
  logic [DROP_WIDTH-1:0]   fl_drop_cnt;
  logic [DROP_WIDTH-1:0]   nr_drop_cnt;
  modport slave (
    input  clear, fl_valid, fl_in, nr_valid, nr_in, fl_out_ready, nr_out_ready,
    output fl_out_valid, fl_out_data, nr_out_valid, nr_out_data,
           fl_count, nr_count, fl_overflow, nr_overflow, fl_drop_cnt, nr_drop_cnt
  );
  modport master (
    output clear, fl_valid, fl_in, nr_valid, nr_in, fl_out_ready, nr_out_ready,
    input  fl_out_valid, fl_out_data, nr_out_valid, nr_out_data,
           fl_count, nr_count, fl_overflow, nr_overflow, fl_drop_cnt, nr_drop_cnt
  );
endinterface

// File: rtl/free_list_controller.sv
// free_list_controller: two independent FWFT FIFOs for free-list and no-redundancy indices.
// Define FLC_DROP_COUNT_EN to enable saturating per-FIFO drop counters.
module free_list_controller #(
  parameter int ITER_WIDTH   = 9,
  parameter int FL_DEPTH     = 16,
  parameter int NR_DEPTH     = 16,
  parameter int FL_PTR_WIDTH = 4,
  parameter int NR_PTR_WIDTH = 4,
  parameter int DROP_WIDTH   = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  free_list_controller_if.slave bus
);
  logic [ITER_WIDTH-1:0]   r_fl_mem [FL_DEPTH];
  logic [FL_PTR_WIDTH-1:0] r_fl_wp, r_fl_rp;
  logic [FL_PTR_WIDTH:0]   r_fl_cnt;
  logic                    r_fl_ovf;
  logic                    w_fl_empty, w_fl_pop, w_fl_push, w_fl_drop;
  logic [ITER_WIDTH-1:0]   r_nr_mem [NR_DEPTH];
  logic [NR_PTR_WIDTH-1:0] r_nr_wp, r_nr_rp;
  logic [NR_PTR_WIDTH:0]   r_nr_cnt;
  logic                    r_nr_ovf;
  logic                    w_nr_empty, w_nr_pop, w_nr_push, w_nr_drop;
  // count MSB alone marks full because depth is a power of two
  assign w_fl_empty = r_fl_cnt == '0;
  assign w_fl_pop   = ~w_fl_empty & bus.fl_out_ready;
  assign w_fl_push  = bus.fl_valid & (~r_fl_cnt[FL_PTR_WIDTH] | w_fl_pop);
  assign w_fl_drop  = bus.fl_valid & ~w_fl_push;
  assign w_nr_empty = r_nr_cnt == '0;
  assign w_nr_pop   = ~w_nr_empty & bus.nr_out_ready;
  assign w_nr_push  = bus.nr_valid & (~r_nr_cnt[NR_PTR_WIDTH] | w_nr_pop);
  assign w_nr_drop  = bus.nr_valid & ~w_nr_push;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_fl_wp  <= '0;
      r_fl_rp  <= '0;
      r_fl_cnt <= '0;
      r_fl_ovf <= 1'b0;
      r_nr_wp  <= '0;
      r_nr_rp  <= '0;
      r_nr_cnt <= '0;
      r_nr_ovf <= 1'b0;
    end else if (bus.clear) begin
      r_fl_wp  <= '0;
      r_fl_rp  <= '0;
      r_fl_cnt <= '0;
      r_fl_ovf <= 1'b0;
      r_nr_wp  <= '0;
      r_nr_rp  <= '0;
      r_nr_cnt <= '0;
      r_nr_ovf <= 1'b0;
    end else begin
      if (w_fl_push) r_fl_wp <= r_fl_wp + 1'b1;
      if (w_fl_pop) r_fl_rp <= r_fl_rp + 1'b1;
      r_fl_cnt <= (w_fl_push & ~w_fl_pop) ? r_fl_cnt + 1'b1 :
                  (w_fl_pop & ~w_fl_push) ? r_fl_cnt - 1'b1 : r_fl_cnt;
      if (w_fl_drop) r_fl_ovf <= 1'b1;
      if (w_nr_push) r_nr_wp <= r_nr_wp + 1'b1;
      if (w_nr_pop) r_nr_rp <= r_nr_rp + 1'b1;
      r_nr_cnt <= (w_nr_push & ~w_nr_pop) ? r_nr_cnt + 1'b1 :
                  (w_nr_pop & ~w_nr_push) ? r_nr_cnt - 1'b1 : r_nr_cnt;
      if (w_nr_drop) r_nr_ovf <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (w_fl_push && !bus.clear) r_fl_mem[r_fl_wp] <= bus.fl_in;
    if (w_nr_push && !bus.clear) r_nr_mem[r_nr_wp] <= bus.nr_in;
  end
  assign bus.fl_out_valid = ~w_fl_empty;
  assign bus.fl_out_data  = w_fl_empty ? '0 : r_fl_mem[r_fl_rp];
  assign bus.fl_count     = r_fl_cnt;
  assign bus.fl_overflow  = r_fl_ovf;
  assign bus.nr_out_valid = ~w_nr_empty;
  assign bus.nr_out_data  = w_nr_empty ? '0 : r_nr_mem[r_nr_rp];
  assign bus.nr_count     = r_nr_cnt;
  assign bus.nr_overflow  = r_nr_ovf;
`ifdef FLC_DROP_COUNT_EN
  logic [DROP_WIDTH-1:0] r_fl_dc, r_nr_dc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_fl_dc <= '0;
      r_nr_dc <= '0;
    end else if (bus.clear) begin
      r_fl_dc <= '0;
      r_nr_dc <= '0;
    end else begin
      if (w_fl_drop && r_fl_dc != '1) r_fl_dc <= r_fl_dc + 1'b1;
      if (w_nr_drop && r_nr_dc != '1) r_nr_dc <= r_nr_dc + 1'b1;
    end
  assign bus.fl_drop_cnt = r_fl_dc;
  assign bus.nr_drop_cnt = r_nr_dc;
`else
  assign bus.fl_drop_cnt = {DROP_WIDTH{1'b0}};
  assign bus.nr_drop_cnt = {DROP_WIDTH{1'b0}};
`endif
endmodule
